// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cs/ack memory port between an instruction-fetch
// requester and a load/store requester. Each access runs IDLE -> GRANT ->
// RELEASE. A watchdog aborts accesses that the memory never acknowledges.
module mem_arbiter #(
  parameter int PRIORITY_MODE = 0,   // 0 = round-robin, 1 = data port wins ties
  parameter int TIMEOUT       = 15   // GRANT cycles without mem_ack before abort (2..255)
) (
  input  logic        clock,
  input  logic        cpu_rst,
  input  logic        i_cs,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_cs,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Watchdog value at which the next un-acked GRANT cycle aborts.
  localparam logic [7:0]  WDOG_LAST  = 8'(TIMEOUT - 1);
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t     state, state_nx;
  logic       gnt_d;     // owner of the current access: 1 = data port
  logic       last_d;    // last normally-completed winner: 1 = data port
  logic [7:0] wdog;

  // Strobes from the FSM to the datapath registers.
  logic take;            // grant issued this cycle
  logic take_d;          // grant goes to the data port
  logic done;            // memory acknowledged the access
  logic abort;           // watchdog expired

  // State register; an asserted reset abandons any access in flight.
  always_ff @(posedge clock or posedge cpu_rst) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic, arbitration decision and completion strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nx = state;
    take     = 1'b0;
    take_d   = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (i_cs || d_cs) begin
          take     = 1'b1;
          state_nx = GRANT;
          if (d_cs && !i_cs)     take_d = 1'b1;
          else if (d_cs && i_cs) take_d = (PRIORITY_MODE == 1) ? 1'b1 : !last_d;
        end
      end
      GRANT: begin
        if (mem_ack) begin
          done     = 1'b1;
          state_nx = RELEASE;
        end else if (wdog == WDOG_LAST) begin
          abort    = 1'b1;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        // Hold off new grants until the memory has dropped its ack.
        if (!mem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory-side registers, watchdog, owner tracking and requester responses.
  always_ff @(posedge clock or posedge cpu_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (cpu_rst) begin
      // NOTE: the read-data holding registers are plain flops, so they are
      // reset along with the control state to give defined outputs.
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt_d     <= 1'b0;
      last_d    <= 1'b0;
      wdog      <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      bus_err   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;

      if (take) begin
        gnt_d     <= take_d;
        mem_addr  <= take_d ? d_addr : i_addr;
        mem_wdata <= d_wdata;
        mem_we    <= take_d & d_we;
        mem_cs    <= 1'b1;
        wdog      <= '0;
      end

      if (state == GRANT && !done && !abort) wdog <= wdog + 8'd1;

      if (done) begin
        if (gnt_d) begin
          d_rdata <= mem_rdata;
          d_ack   <= 1'b1;
        end else begin
          i_rdata <= mem_rdata;
          i_ack   <= 1'b1;
        end
        mem_cs <= 1'b0;
        mem_we <= 1'b0;
        last_d <= gnt_d;
      end

      if (abort) begin
        if (gnt_d) begin
          d_rdata <= ABORT_DATA;
          d_ack   <= 1'b1;
        end else begin
          i_rdata <= ABORT_DATA;
          i_ack   <= 1'b1;
        end
        bus_err <= 1'b1;
        mem_cs  <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

endmodule
